// File: rtl/serial_nibble_adder_ctrl.sv
// Bit-serial (nibble-at-a-time) add/subtract sequencer around a single 4-bit ripple adder.
// Command and result sides are valid/ready; one operation is in flight at a time.
module serial_nibble_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [WIDTH-1:0] cmd_a_i,
  input  logic [WIDTH-1:0] cmd_b_i,
  input  logic             cmd_sub_i,
  input  logic             cmd_cin_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_sum_o,
  output logic             res_cout_o,
  output logic             res_ovf_o,
  output logic             busy_o
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] KLast = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [KW-1:0]    k_q;
  logic             carry_q, cout_q, ovf_q;

  logic [3:0] a_nib, b_nib;
  logic [4:0] nib_sum;

  // The one shared 4-bit adder; operand nibble is selected by k_q.
  always_comb begin
    a_nib   = a_q[{k_q, 2'b00} +: 4];
    b_nib   = b_q[{k_q, 2'b00} +: 4];
    nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            a_q     <= cmd_a_i;
            b_q     <= cmd_b_i ^ {WIDTH{cmd_sub_i}};
            carry_q <= cmd_sub_i | cmd_cin_i;
            k_q     <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q[{k_q, 2'b00} +: 4] <= nib_sum[3:0];
          carry_q                  <= nib_sum[4];
          if (k_q == KLast) begin
            k_q     <= '0;
            cout_q  <= nib_sum[4];
            // Top nibble's MSB is the result sign bit.
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[3] != a_q[WIDTH-1]);
            state_q <= StDone;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StDone: begin
          if (res_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign res_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign res_sum_o   = sum_q;
  assign res_cout_o  = cout_q;
  assign res_ovf_o   = ovf_q;

endmodule
